video_fb_rd_sched: RTL

- Schedules frame-buffer read bursts that keep the display line FIFO filled ahead of the video timing generator's pixel requests.
- Detects frame start from vsync, flushes the FIFO and picks the most recently completed ping-pong buffer.
- Issues one outstanding burst at a time, each sized to free FIFO space, until h_disp*v_disp words of the frame are read.
- Counts display underflows for debug.

---
 rtl/video_fb_rd_sched_pkg.sv | 19 +
 rtl/video_fb_rd_sched_if.sv | 13 +
 rtl/video_fb_rd_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/video_fb_rd_sched_pkg.sv
// Shared types and default constants for the frame-buffer read scheduler.
// The remaining/offset counters are sized for a full 11x11-bit frame area.
package video_pkg;

  localparam int REM_W = 22;

  localparam int DEF_BURST_LEN = 64;
  localparam int DEF_FIFO_DEPTH = 1024;
  localparam logic [27:0] DEF_BUF_STRIDE = 28'h0200000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_CHECK = 3'd2,
    ST_REQ   = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/video_fb_rd_sched_if.sv
// Burst read channel between the scheduler (master) and the frame-buffer reader.
interface video_fb_rd_sched_if #(
  parameter int ADDR_W = 28
);
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_done;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface

// File: rtl/video_fb_rd_sched.sv
// Keeps the display line FIFO topped up with one-outstanding frame-buffer bursts,
// restarting on every vsync falling edge from the newest completed buffer.
module video_fb_rd_sched
  import video_pkg::*;
#(
  parameter int              ADDR_W     = 28,
  parameter int              LVL_W      = 11,
  parameter int              FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int              BURST_LEN  = DEF_BURST_LEN,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = DEF_BUF_STRIDE
) (
  input  logic               pixel_clk,
  input  logic               sys_rst,
  input  logic               video_vs,
  input  logic [10:0]        h_disp,
  input  logic [10:0]        v_disp,
  input  logic               wr_buf_done,
  input  logic               wr_buf_idx,
  input  logic [LVL_W-1:0]   fifo_level,
  input  logic               data_req,
  input  logic               fifo_empty,
  output logic               fifo_flush,
  output logic               rd_buf_idx,
  output logic [15:0]        underflow_cnt,
  video_fb_rd_sched_if.master rd
);

  state_e           state;
  logic             vs_d;
  logic             vs_fall;
  logic             latest;
  logic             latest_vld;
  logic             restart_pend;
  logic [REM_W-1:0] remaining;
  logic [REM_W-1:0] offset;
  logic [7:0]       len_next;
  logic [LVL_W:0]   need;
  logic             fits;

  assign vs_fall    = vs_d & ~video_vs;
  assign fifo_flush = (state == ST_FLUSH);
  assign rd.rd_req  = (state == ST_REQ);

  // Burst is clipped to what is left of the frame; space check is one bit wider than the level
  always_comb begin
    len_next = 8'(BURST_LEN);
    if (remaining < REM_W'(BURST_LEN))
      len_next = remaining[7:0];
    need = {1'b0, fifo_level} + (LVL_W+1)'(len_next);
    fits = (need <= (LVL_W+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      vs_d         <= 1'b1;
      latest       <= 1'b0;
      latest_vld   <= 1'b0;
      restart_pend <= 1'b0;
      remaining    <= '0;
      offset       <= '0;
      rd_buf_idx   <= 1'b0;
      rd.rd_addr   <= '0;
      rd.rd_len    <= '0;
    end else begin
      vs_d <= video_vs;
      if (wr_buf_done) begin
        latest     <= wr_buf_idx;
        latest_vld <= 1'b1;
      end
      case (state)
        ST_IDLE: if (vs_fall) state <= ST_FLUSH;
        ST_FLUSH: begin
          remaining    <= REM_W'(h_disp) * REM_W'(v_disp);
          offset       <= '0;
          restart_pend <= 1'b0;
          if (latest_vld) rd_buf_idx <= latest;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (remaining == '0)
            state <= ST_IDLE;
          else if (vs_fall)
            state <= ST_FLUSH;
          else if (fits) begin
            rd.rd_len  <= len_next;
            rd.rd_addr <= (rd_buf_idx ? BUF_STRIDE : '0) + ADDR_W'(offset);
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (vs_fall) restart_pend <= 1'b1;
          if (rd.rd_ack) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (vs_fall) restart_pend <= 1'b1;
          // The in-flight burst always lands before a late frame restart takes effect
          if (rd.rd_done) begin
            offset    <= offset + REM_W'(rd.rd_len);
            remaining <= remaining - REM_W'(rd.rd_len);
            state     <= (restart_pend | vs_fall) ? ST_FLUSH : ST_CHECK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst)
      underflow_cnt <= '0;
    else if (data_req && fifo_empty && (underflow_cnt != 16'hFFFF))
      underflow_cnt <= underflow_cnt + 16'd1;
  end

endmodule
